mdr_mem_unit: RTL

MDR_MEM_UNIT -- requirements
Module: mdr_mem_unit

---
 rtl/mdr_mem_unit_if.sv | 51 +++++
 rtl/mdr_mem_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mdr_mem_unit_if.sv
// ---------------------------------------------------------------------------
// mdr_mem_unit_if
//   Bundles the datapath-bus side and the memory side of the MAR/MDR memory
//   unit into one interface.
//
//   Datapath side : BusMuxOut, MARin, MDRin, rd_start, wr_start (to unit)
//                   BusMuxInMDR, busy, done, err            (from unit)
//   Memory side   : mem_rdata, mem_ready                     (to unit)
//                   mem_addr, mem_wdata, mem_rd, mem_wr      (from unit)
//
//   Modports:
//     slave  - the memory unit itself
//     master - whatever drives the unit (controller / testbench)
// ---------------------------------------------------------------------------
interface mdr_mem_unit_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    // Datapath bus side
    logic [DATA_W-1:0] BusMuxOut;
    logic              MARin;
    logic              MDRin;
    logic              rd_start;
    logic              wr_start;
    logic [DATA_W-1:0] BusMuxInMDR;
    logic              busy;
    logic              done;
    logic              err;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  BusMuxOut, MARin, MDRin, rd_start, wr_start,
        input  mem_rdata, mem_ready,
        output BusMuxInMDR, busy, done, err,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output BusMuxOut, MARin, MDRin, rd_start, wr_start,
        output mem_rdata, mem_ready,
        input  BusMuxInMDR, busy, done, err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mdr_mem_unit.sv
// ---------------------------------------------------------------------------
// mdr_mem_unit
//   Memory Address Register (MAR) and Memory Data Register (MDR) together
//   with a small read/write sequencer talking to a ready-strobed memory.
//
//   Ports:
//     clk  - single clock, all state changes on the rising edge
//     clr  - synchronous active-high reset (aborts any access, no done)
//     bus  - mdr_mem_unit_if.slave:
//              BusMuxOut/MARin/MDRin load MAR/MDR while idle,
//              rd_start/wr_start launch an access,
//              mem_addr/mem_wdata/mem_rd/mem_wr/mem_rdata/mem_ready talk
//              to memory, BusMuxInMDR presents MDR to the bus mux,
//              busy/done/err report access status.
//
//   Build option:
//     MDR_TIMEOUT_EN - when defined, an access that sees no mem_ready for
//                      TIMEOUT wait cycles is abandoned with done=1, err=1.
//                      When undefined, accesses wait forever and err=0.
// ---------------------------------------------------------------------------
module mdr_mem_unit #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           clr,
    mdr_mem_unit_if.slave  bus
);

    // Catch nonsensical configurations at elaboration time.
    if (TIMEOUT < 1 || ADDR_W > DATA_W || ADDR_W < 1) begin : g_param_check
        $error("mdr_mem_unit: need TIMEOUT >= 1 and 1 <= ADDR_W <= DATA_W");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    // Only the address bits that reach memory are kept; upper MAR bits
    // are never observable.
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              done_q, done_d;

`ifdef MDR_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             err_q, err_d;
`endif

    // Next-state / register-update logic
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
`ifdef MDR_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Bus loads are only honoured here, which keeps MAR/MDR
                // stable for the whole duration of an access.
                if (bus.MARin) mar_d = bus.BusMuxOut[ADDR_W-1:0];
                if (bus.MDRin) mdr_d = bus.BusMuxOut;
                // Read has priority when both starts coincide.
                if (bus.rd_start || bus.wr_start) begin
                    state_d = bus.rd_start ? RD_WAIT : WR_WAIT;
`ifdef MDR_TIMEOUT_EN
                    wcnt_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (bus.mem_ready) begin
                    if (state_q == RD_WAIT) mdr_d = bus.mem_rdata;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`ifdef MDR_TIMEOUT_EN
                else if (wcnt_q == CNT_LAST) begin
                    // This is the TIMEOUT-th cycle without mem_ready.
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            wcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
`ifdef MDR_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.mem_addr    = mar_q;
    assign bus.mem_wdata   = mdr_q;
    assign bus.BusMuxInMDR = mdr_q;
    assign bus.mem_rd      = (state_q == RD_WAIT);
    assign bus.mem_wr      = (state_q == WR_WAIT);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
`ifdef MDR_TIMEOUT_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif

endmodule
